// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, default bit timing and 8N1 frame constants.
package uart_pkg;

  localparam int CLOCKS_PER_BIT = 40;
  localparam int DATA_BITS      = 8;
  localparam logic STOP_LEVEL   = 1'b1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] STOP    = 3'd3;
  localparam logic [2:0] RECOVER = 3'd4;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Receiver-side bundle: serial line in, byte strobe / framing error / busy out.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx_pin;
  logic [DATA_BITS-1:0] out_byte;
  logic                 out_byte_ready;
  logic                 out_framing_error;
  logic                 out_busy;

  modport master (
    input  rx_pin,
    output out_byte, out_byte_ready, out_framing_error, out_busy
  );

  modport slave (
    output rx_pin,
    input  out_byte, out_byte_ready, out_framing_error, out_busy
  );

endinterface

// File: rtl/uart_rx_deserializer_bit_sync.sv
// Metastability chain for the asynchronous RX line; resets to the idle (high) level
// so a reset can never look like a start bit.
module uart_bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) chain <= '1;
    else       chain <= {chain[SYNC_STAGES-2:0], din};
  end

  assign dout = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 oversampling UART receiver with one-cycle byte and framing-error strobes.
// Define UART_RX_MAJORITY_EN to vote each decision over the last three samples.
module uart_rx_deserializer #(
  parameter int CLOCKS_PER_BIT = uart_pkg::CLOCKS_PER_BIT,
  parameter int SYNC_STAGES    = 2
) (
  input  logic     clock,
  input  logic     reset,
  uart_rx_if.master bus
);
  import uart_pkg::*;

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] LAST      = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 bit_val;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 ready_reg;
  logic                 ferr_reg;

  uart_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .din   (bus.rx_pin),
    .dout  (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // History shifts every cycle, so at a decision count it holds the two prior samples.
  logic [1:0] hist;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) hist <= 2'b11;
    else       hist <= {hist[0], rx_s};
  end

  assign bit_val = majority3(hist[1], hist[0], rx_s);
`else
  assign bit_val = rx_s;
`endif

  // The IDLE detection cycle counts as the first half-bit cycle, hence START begins at cnt=1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data_reg  <= '0;
      ready_reg <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      ready_reg <= 1'b0;
      ferr_reg  <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= CW'(1);
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!bit_val) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) state <= STOP;
            else                     bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (bit_val == STOP_LEVEL) begin
              data_reg  <= shreg;
              ready_reg <= 1'b1;
              state     <= IDLE;
            end else begin
              ferr_reg <= 1'b1;
              state    <= RECOVER;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RECOVER: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_byte          = data_reg;
  assign bus.out_byte_ready    = ready_reg;
  assign bus.out_framing_error = ferr_reg;
  assign bus.out_busy          = (state != IDLE);

endmodule
